alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  FIFO not full; transfer when cmd_valid&&cmd_ready.
REQ-006 cmd_a, cmd_b  input  32 each  operands.
REQ-007 cmd_sel  input  4  opcode: 0000 AND, 0001 OR, 0010 NOT(A), 0011 NOR, 0100 XOR, 0101 NAND, 0110 ADD, 0111 SUB; 1000-1111 illegal.
REQ-008 cmd_cin  input  1  carry-in, used by ADD only.
REQ-009 alu_a, alu_b  output  32 each  operands driven to the external combinational ALU.
REQ-010 alu_sel  output  4  opcode to ALU; alu_cin  output  1  carry to ALU.
REQ-011 alu_y  input  32; alu_cout, alu_neg, alu_zero, alu_ovf  input  1 each  ALU results.
REQ-012 res_valid  output  1  result held; res_ready  input  1  consumer accepts.
REQ-013 res_y  output  32; res_cout, res_neg, res_zero, res_ovf, res_err  output  1 each.

Function
REQ-014 The block SHALL buffer commands in a DEPTH-entry FIFO, in order, storing {a,b,sel,cin}.
REQ-015 cmd_ready SHALL equal (count != DEPTH); a push when full SHALL never occur.
REQ-016 FSM states SHALL be IDLE, DRIVE, CAPT, HOLD.
REQ-017 IDLE: if count!=0, pop head into operand register, go DRIVE; else stay.
REQ-018 DRIVE: alu_* SHALL present the operand register for exactly one cycle for settling; next CAPT.
REQ-019 CAPT: alu_* still driven; register alu_y and flags into res_*; set res_valid; go HOLD.
REQ-020 HOLD: res_* SHALL remain stable while res_valid&&!res_ready; on res_ready go IDLE and clear res_valid the next cycle.
REQ-021 Outside DRIVE/CAPT, alu_a/alu_b SHALL be 0, alu_sel 0000, alu_cin 0.
REQ-022 For SUB, alu_cin SHALL be forced 1 (A + ~B + 1) regardless of cmd_cin; for logic ops alu_cin SHALL be 0.
REQ-023 Illegal opcode: skip ALU drive (alu_* stay 0), go IDLE->CAPT directly, capture res_y=0, flags 0, res_err=1.
REQ-024 res_err SHALL be 0 for legal opcodes.
REQ-025 Latency: command pushed into empty FIFO with FSM IDLE at edge N -> popped at N+1, CAPT at N+2, res_valid=1 after edge N+3 (illegal: after N+2).
REQ-026 Throughput: one result per 4 cycles with res_ready held 1.
REQ-027 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-028 Pushes SHALL continue while the FSM is in DRIVE/CAPT/HOLD.

Reset
REQ-029 When rst_n=0 at a rising edge: count=0, pointers=0, FSM=IDLE, res_valid=0, res_* =0, operand register=0.
REQ-030 Reset mid-operation SHALL discard queued and in-flight commands; no result for them is ever presented.
REQ-031 cmd_ready SHALL be 1 during and after reset (FIFO empty).

Verification
REQ-032 ADD a=0xFFFFFFFF b=1 cin=0, res_ready=1 -> res_y=0, cout=1, zero=1, neg=0, ovf=0, res_valid 3 cycles after push.
REQ-033 SUB a=0x80000000 b=1 cin=0 -> res_y=0x7FFFFFFF, ovf=1, neg=0, alu_cin observed 1 during DRIVE/CAPT.
REQ-034 Push DEPTH+1 commands back-to-back with res_ready=0 -> cmd_ready low after DEPTH-0 stall behaviour: first result held stable, FIFO full, cmd_ready=0 until first res_ready; results later drain in push order.
REQ-035 Opcode 1010 then AND 0xF0F0F0F0&0xFF00FF00 -> first result res_err=1 y=0 with alu_sel never 1010; second y=0xF000F000, err=0.
REQ-036 rst_n=0 for one cycle while in HOLD with 2 queued -> res_valid=0, cmd_ready=1, no further results without new pushes.
REQ-037 NOT a=0 b=X -> res_y=0xFFFFFFFF, neg=1, zero=0; alu_cin=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands in a small FIFO and sequences each one through an external
// combinational ALU: drive for a settling cycle, capture, then hold until accepted.
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_sel,
  input  logic        cmd_cin,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic        alu_cin,
  input  logic [31:0] alu_y,
  input  logic        alu_cout,
  input  logic        alu_neg,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_y,
  output logic        res_cout,
  output logic        res_neg,
  output logic        res_zero,
  output logic        res_ovf,
  output logic        res_err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [3:0]    OP_ADD     = 4'b0110;
  localparam logic [3:0]    OP_SUB     = 4'b0111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        cin;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, CAPT, HOLD} state_t;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  state_t        state;
  cmd_t          op_q;
  cmd_t          head;
  logic          push;
  logic          pop;
  logic          drive_en;

  assign cmd_ready = (count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);

  // NOTE: head is fully assigned before the conditional overrides, so no latch is inferred.
  always_comb begin
    head = mem[rd_ptr];
    // SUB runs as A + ~B + 1, so its carry is forced; only ADD honours the command's carry.
    if (head.sel == OP_SUB)      head.cin = 1'b1;
    else if (head.sel != OP_ADD) head.cin = 1'b0;
  end

  // NOTE: the storage array has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel, cmd_cin};
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_cout  <= 1'b0;
      res_neg   <= 1'b0;
      res_zero  <= 1'b0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            op_q  <= head;
            // Illegal opcodes never touch the ALU and go straight to capture.
            state <= head.sel[3] ? CAPT : DRIVE;
          end
        end
        DRIVE: state <= CAPT;
        CAPT: begin
          res_valid <= 1'b1;
          res_err   <= op_q.sel[3];
          if (op_q.sel[3]) begin
            res_y    <= '0;
            res_cout <= 1'b0;
            res_neg  <= 1'b0;
            res_zero <= 1'b0;
            res_ovf  <= 1'b0;
          end else begin
            res_y    <= alu_y;
            res_cout <= alu_cout;
            res_neg  <= alu_neg;
            res_zero <= alu_zero;
            res_ovf  <= alu_ovf;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign drive_en = ((state == DRIVE) || (state == CAPT)) && !op_q.sel[3];
  assign alu_a    = drive_en ? op_q.a   : '0;
  assign alu_b    = drive_en ? op_q.b   : '0;
  assign alu_sel  = drive_en ? op_q.sel : '0;
  assign alu_cin  = drive_en ? op_q.cin : 1'b0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the alu_* side, arithmetic reference
// model feeding an in-order result queue, directed corner steps then randomized traffic.
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;

  typedef struct packed {
    logic [31:0] y;
    logic        cout;
    logic        neg;
    logic        zero;
    logic        ovf;
    logic        err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_cin = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic        alu_cin;
  logic [31:0] alu_y;
  logic        alu_cout, alu_neg, alu_zero, alu_ovf;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_y;
  logic        res_cout, res_neg, res_zero, res_ovf, res_err;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_cout(res_cout), .res_neg(res_neg), .res_zero(res_zero),
    .res_ovf(res_ovf), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // External ALU; an illegal opcode yields obvious garbage so leakage would show up.
  logic [31:0] alu_bb;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bb   = (alu_sel == OP_SUB) ? ~alu_b : alu_b;
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_bb} + {32'd0, alu_cin};
    alu_y    = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_sel)
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      OP_NOT:  alu_y = ~alu_a;
      OP_NOR:  alu_y = ~(alu_a | alu_b);
      OP_XOR:  alu_y = alu_a ^ alu_b;
      OP_NAND: alu_y = ~(alu_a & alu_b);
      OP_ADD, OP_SUB: begin
        alu_y    = alu_sum[31:0];
        alu_cout = alu_sum[32];
        alu_ovf  = (alu_a[31] == alu_bb[31]) && (alu_sum[31] != alu_a[31]);
      end
      default: begin
        alu_y    = 32'hDEAD_BEEF;
        alu_cout = 1'b1;
        alu_ovf  = 1'b1;
      end
    endcase
    alu_neg  = alu_y[31];
    alu_zero = (alu_y == '0);
  end

  function automatic res_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] sel, input logic cin);
    res_t            r;
    longint unsigned u;
    longint          s;
    r = '0;
    if (sel > 4'd7) begin
      r.err = 1'b1;
      return r;
    end
    case (sel)
      OP_AND:  r.y = a & b;
      OP_OR:   r.y = a | b;
      OP_NOT:  r.y = ~a;
      OP_NOR:  r.y = ~(a | b);
      OP_XOR:  r.y = a ^ b;
      OP_NAND: r.y = ~(a & b);
      OP_ADD: begin
        u      = longint'(a) + longint'(b) + longint'(cin);
        r.y    = u[31:0];
        r.cout = u[32];
        s      = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        r.ovf  = (s != longint'($signed(r.y)));
      end
      OP_SUB: begin
        r.y    = a - b;
        r.cout = (a >= b);
        s      = longint'($signed(a)) - longint'($signed(b));
        r.ovf  = (s != longint'($signed(r.y)));
      end
      default: r.y = '0;
    endcase
    r.neg  = r.y[31];
    r.zero = (r.y == 32'd0);
    return r;
  endfunction

  function automatic logic exp_cin(input logic [3:0] sel, input logic cin);
    if (sel == OP_ADD) return cin;
    return (sel == OP_SUB);
  endfunction

  function automatic res_t observed();
    return {res_y, res_cout, res_neg, res_zero, res_ovf, res_err};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one command from a negedge, waits (bounded) for space, returns at the next negedge.
  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] sel, input logic cin);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_cin   = cin;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check("push_timeout_cmd_ready", 64'(cmd_ready), 64'd1);
    else begin
      @(posedge clk);
      exp_q.push_back(ref_result(a, b, sel, cin));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Pushes into an idle sequencer with res_ready high and checks the cycle-by-cycle timeline.
  task automatic push_and_watch(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] sel, input logic cin);
    push(a, b, sel, cin);
    check({tag, "_valid_n0"}, 64'(res_valid), 64'd0);
    @(negedge clk);
    if (sel <= 4'd7) begin
      check({tag, "_drive_a"}, 64'(alu_a), 64'(a));
      check({tag, "_drive_b"}, 64'(alu_b), 64'(b));
      check({tag, "_drive_sel"}, 64'(alu_sel), 64'(sel));
      check({tag, "_drive_cin"}, 64'(alu_cin), 64'(exp_cin(sel, cin)));
      check({tag, "_valid_n1"}, 64'(res_valid), 64'd0);
      @(negedge clk);
      check({tag, "_capt_sel"}, 64'(alu_sel), 64'(sel));
      check({tag, "_capt_cin"}, 64'(alu_cin), 64'(exp_cin(sel, cin)));
      check({tag, "_valid_n2"}, 64'(res_valid), 64'd0);
      @(negedge clk);
    end else begin
      check({tag, "_illegal_alu_a"}, 64'(alu_a), 64'd0);
      check({tag, "_illegal_alu_b"}, 64'(alu_b), 64'd0);
      check({tag, "_illegal_alu_sel"}, 64'(alu_sel), 64'd0);
      check({tag, "_illegal_alu_cin"}, 64'(alu_cin), 64'd0);
      check({tag, "_valid_n1"}, 64'(res_valid), 64'd0);
      @(negedge clk);
    end
    check({tag, "_valid_at_latency"}, 64'(res_valid), 64'd1);
    check({tag, "_result"}, 64'(observed()), 64'(ref_result(a, b, sel, cin)));
    check({tag, "_alu_released"}, 64'(alu_sel), 64'd0);
  endtask

  // Result scoreboard, hold-stability and opcode-legality monitor, sampled 1ns after negedge.
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_rst   = 1'b0;
  res_t prev_res   = '0;
  res_t mon_exp;
  always @(negedge clk) begin
    #1;
    check("alu_sel_legal", 64'(alu_sel[3]), 64'd0);
    if (prev_valid && !prev_ready && prev_rst)
      check("hold_stable", 64'({res_valid, observed()}), 64'({1'b1, prev_res}));
    if (res_valid && res_ready && rst_n) begin
      if (exp_q.size() == 0) check("unexpected_result", 64'(res_valid), 64'd0);
      else begin
        mon_exp = exp_q.pop_front();
        check("result_in_order", 64'(observed()), 64'(mon_exp));
      end
    end
    prev_valid = res_valid;
    prev_ready = res_ready;
    prev_rst   = rst_n;
    prev_res   = observed();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   guard;
    int   last_hi;
    int   n_hi;
    int   r;
    bit   rand_done;
    logic [3:0] sel;

    // Reset state, sampled while rst_n is still low and again after release.
    rst_n     = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_res", 64'(observed()), 64'd0);
    check("reset_alu_a", 64'(alu_a), 64'd0);
    check("reset_alu_sel", 64'(alu_sel), 64'd0);
    check("reset_alu_cin", 64'(alu_cin), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_reset_res_valid", 64'(res_valid), 64'd0);

    // Directed single commands with exact timeline.
    push_and_watch("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0);
    check("add_wrap_y_zero", 64'({res_y, res_cout, res_zero, res_neg, res_ovf}), 64'({32'd0, 4'b1100}));
    push_and_watch("sub_ovf", 32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0);
    check("sub_ovf_y", 64'({res_y, res_ovf, res_neg}), 64'({32'h7FFF_FFFF, 2'b10}));
    push_and_watch("sub_cin_ignored", 32'd10, 32'd3, OP_SUB, 1'b1);
    push_and_watch("add_cin", 32'd5, 32'd7, OP_ADD, 1'b1);
    push_and_watch("not_zero", 32'h0000_0000, $urandom, OP_NOT, 1'b1);
    check("not_zero_y", 64'({res_y, res_neg, res_zero}), 64'({32'hFFFF_FFFF, 2'b10}));
    push_and_watch("xor_mix", 32'h1234_5678, 32'hFFFF_0000, OP_XOR, 1'b0);
    push_and_watch("illegal_1010", 32'hAAAA_5555, 32'h1111_2222, 4'b1010, 1'b1);
    check("illegal_err", 64'({res_y, res_err}), 64'({32'd0, 1'b1}));
    push_and_watch("and_after_illegal", 32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 1'b0);
    check("and_after_illegal_y", 64'({res_y, res_err}), 64'({32'hF000_F000, 1'b0}));

    // Throughput: three back-to-back commands, results every fourth cycle.
    push(32'd1, 32'd2, OP_ADD, 1'b0);
    push(32'hFFFF_0000, 32'h00FF_FF00, OP_OR, 1'b0);
    push(32'd9, 32'd9, OP_SUB, 1'b0);
    last_hi = -1;
    n_hi    = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (res_valid) begin
        if (last_hi >= 0) check("throughput_gap", 64'(c - last_hi), 64'd4);
        last_hi = c;
        n_hi++;
      end
    end
    check("throughput_count", 64'(n_hi), 64'd3);

    // Fill: DEPTH+1 pushes with the consumer stalled, a blocked offer, then in-order drain.
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(rand_word(), rand_word(), 4'($urandom_range(0, 7)), 1'($urandom));
    check("full_cmd_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1;
    cmd_a     = 32'hBAD0_BAD0;
    cmd_b     = 32'h0BAD_0BAD;
    cmd_sel   = OP_XOR;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_stall_cmd_ready", 64'(cmd_ready), 64'd0);
      check("full_stall_res_valid", 64'(res_valid), 64'd1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("full_drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("full_drain_cmd_ready", 64'(cmd_ready), 64'd1);
    check("full_drain_res_valid", 64'(res_valid), 64'd0);

    // Reset while holding a result with two commands still queued.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(rand_word(), rand_word(), OP_ADD, 1'b0);
    guard = 0;
    while (!res_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rst_hold_reached", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_res_valid", 64'(res_valid), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_mid_res", 64'(observed()), 64'd0);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_no_stale_result", 64'(res_valid), 64'd0);
    end

    // Randomized traffic against the reference queue with a randomly stalling consumer.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          r   = $urandom_range(0, 9);
          sel = (r < 8) ? 4'(r) : 4'($urandom_range(8, 15));
          push(rand_word(), rand_word(), sel, 1'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("random_drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("final_idle_res_valid", 64'(res_valid), 64'd0);
    check("final_cmd_ready", 64'(cmd_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
